serial_bit_feeder: RTL and testbench

Upstream stage for the serial sequence detector: accepts parallel words through a valid/ready handshake, buffers them in a small FIFO and shifts them out one bit per clock onto the detector's serial input `x`. Back-to-back words stream with no idle bits between them. When no data is buffered, a fixed idle level is driven. Word and bit boundaries are flagged for the bench and for downstream monitoring.

---
 rtl/serial_bit_feeder.sv | 198 +++++++++++++++++++
 tb/tb_serial_bit_feeder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_bit_feeder
//  Purpose  : Accepts parallel words over a valid/ready handshake, buffers
//             them in a small circular FIFO and shifts them out one bit per
//             clock on x. Consecutive words stream with no idle bits between
//             them; IDLE_BIT is driven while nothing is being shifted.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   rising-edge clock
//    reset        in   asynchronous active-high reset, clears all state
//    din          in   parallel word to serialize (WIDTH bits)
//    din_valid    in   din holds a word
//    din_ready    out  FIFO can accept a word this cycle (combinational)
//    x            out  serial data bit, registered
//    x_valid      out  x carries a data bit, registered
//    frame_start  out  one-cycle pulse with the first bit of each word
//    fifo_level   out  number of words currently buffered
//    words_sent   out  count of fully shifted words, wraps at 16 bits
// ============================================================================
module serial_bit_feeder #(
    parameter int   WIDTH     = 8,
    parameter int   DEPTH     = 4,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic                     x,
    output logic                     x_valid,
    output logic                     frame_start,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              words_sent
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT   = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             x_next;
    logic             x_valid_next;
    logic             frame_start_next;
    logic             word_done;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    // Ready depends only on the registered level, so a pop in the same cycle
    // never opens room for a push while full.
    assign din_ready = (fifo_level < FULL_LEVEL);
    assign push      = din_valid && din_ready;
    assign head      = mem[rd_ptr];

    // ------------------------------------------------------------------------
    // Shifter FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Shifter FSM: next state and next-cycle output values.
    // The shift register holds the bits still to be sent; the bit being
    // presented on x has already been removed from it.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        pop              = 1'b0;
        word_done        = 1'b0;
        x_next           = IDLE_BIT;
        x_valid_next     = 1'b0;
        frame_start_next = 1'b0;
        sreg_next        = sreg;
        cnt_next         = cnt;

        case (state)
            ST_IDLE: begin
                if (fifo_level != '0) begin
                    pop              = 1'b1;
                    state_next       = ST_SHIFT;
                    x_next           = (MSB_FIRST != 0) ? head[WIDTH-1] : head[0];
                    sreg_next        = (MSB_FIRST != 0) ? (head << 1) : (head >> 1);
                    cnt_next         = LAST_CNT;
                    x_valid_next     = 1'b1;
                    frame_start_next = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (cnt == '0) begin
                    // Last bit is on x: this edge completes the word. Chain
                    // straight into the next word when one is buffered.
                    word_done = 1'b1;
                    if (fifo_level != '0) begin
                        pop              = 1'b1;
                        x_next           = (MSB_FIRST != 0) ? head[WIDTH-1] : head[0];
                        sreg_next        = (MSB_FIRST != 0) ? (head << 1) : (head >> 1);
                        cnt_next         = LAST_CNT;
                        x_valid_next     = 1'b1;
                        frame_start_next = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    x_next       = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
                    sreg_next    = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
                    cnt_next     = cnt - 1'b1;
                    x_valid_next = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= IDLE_BIT;
            x_valid     <= 1'b0;
            frame_start <= 1'b0;
            sreg        <= '0;
            cnt         <= '0;
            words_sent  <= '0;
        end else begin
            x           <= x_next;
            x_valid     <= x_valid_next;
            frame_start <= frame_start_next;
            sreg        <= sreg_next;
            cnt         <= cnt_next;
            if (word_done) begin
                words_sent <= words_sent + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and level. Pointers wrap naturally since DEPTH is a
    // power of two.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked by the level alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_bit_feeder
//  Purpose  : Directed self-checking bench for serial_bit_feeder
//             (WIDTH=8, DEPTH=4, MSB first, idle level 0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_bit_feeder;

    logic        clk;
    logic        reset;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        x;
    logic        x_valid;
    logic        frame_start;
    logic [2:0]  fifo_level;
    logic [15:0] words_sent;

    int vectors;
    int miscompares;
    int cyc;

    logic bitq[$];
    int   bitcyc[$];
    int   fscyc[$];

    serial_bit_feeder #(
        .WIDTH    (8),
        .DEPTH    (4),
        .MSB_FIRST(1),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .x          (x),
        .x_valid    (x_valid),
        .frame_start(frame_start),
        .fifo_level (fifo_level),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial stream monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (x_valid) begin
            bitq.push_back(x);
            bitcyc.push_back(cyc);
        end
        if (frame_start) fscyc.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        bitq.delete();
        bitcyc.delete();
        fscyc.delete();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        tick();
        clear_mon();
    endtask

    // Presents one word and holds it until accepted (bounded).
    task automatic push_word(input logic [7:0] w);
        int guard;
        guard = 0;
        din       = w;
        din_valid = 1'b1;
        while (!din_ready && guard < 100) begin
            tick();
            guard++;
        end
        vectors++;
        if (guard >= 100) begin
            miscompares++;
            $display("FAIL push_timeout: din_ready=%0b required 1", din_ready);
        end
        tick();
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if ({x, x_valid, din_ready, fifo_level, words_sent} !== {1'b0, 1'b0, 1'b1, 3'd0, 16'd0}) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: x=%0b xv=%0b rdy=%0b lvl=%0d ws=%0d required 0 0 1 0 0",
                         i, x, x_valid, din_ready, fifo_level, words_sent);
            end
            tick();
        end
    endtask

    task automatic test_single();
        logic [7:0] w;
        logic [7:0] expbits;
        w = 8'b1110_0101;
        expbits = 8'b1110_0101;
        do_reset();
        push_word(w);
        // Just after the push edge: buffered, nothing shifting yet.
        vectors++;
        if (fifo_level !== 3'd1 || x_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_latency: lvl=%0d xv=%0b required 1 0", fifo_level, x_valid);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (x !== expbits[7-i] || x_valid !== 1'b1 || frame_start !== (i == 0)) begin
                miscompares++;
                $display("FAIL single_bit[%0d]: x=%0b xv=%0b fs=%0b required %0b 1 %0b",
                         i, x, x_valid, frame_start, expbits[7-i], (i == 0));
            end
            tick();
        end
        vectors++;
        if (x_valid !== 1'b0 || x !== 1'b0 || words_sent !== 16'd1 || fifo_level !== 3'd0) begin
            miscompares++;
            $display("FAIL single_end: xv=%0b x=%0b ws=%0d lvl=%0d required 0 0 1 0",
                     x_valid, x, words_sent, fifo_level);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic       expq[$];
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        do_reset();
        for (int k = 0; k < 3; k++) push_word(words[k]);
        for (int i = 0; i < 30; i++) tick();
        for (int k = 0; k < 3; k++)
            for (int b = 7; b >= 0; b--) expq.push_back(words[k][b]);
        vectors++;
        if (bitq.size() != 24) begin
            miscompares++;
            $display("FAIL b2b_count: bits=%0d required 24", bitq.size());
        end else begin
            for (int i = 0; i < 24; i++) begin
                vectors++;
                if (bitq[i] !== expq[i] || bitcyc[i] != bitcyc[0] + i) begin
                    miscompares++;
                    $display("FAIL b2b_bit[%0d]: x=%0b cyc_off=%0d required %0b %0d",
                             i, bitq[i], bitcyc[i] - bitcyc[0], expq[i], i);
                end
            end
        end
        vectors++;
        if (fscyc.size() != 3 || fscyc[1] - fscyc[0] != 8 || fscyc[2] - fscyc[1] != 8) begin
            miscompares++;
            $display("FAIL b2b_frame_spacing: pulses=%0d required 3 spaced 8", fscyc.size());
        end
        vectors++;
        if (words_sent !== 16'd3) begin
            miscompares++;
            $display("FAIL b2b_words_sent: got %0d required 3", words_sent);
        end
    endtask

    task automatic test_full();
        logic [7:0] words [6];
        logic       expq[$];
        int stall;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h4B;
        words[3] = 8'h87; words[4] = 8'hF0; words[5] = 8'h69;
        do_reset();
        for (int k = 0; k < 5; k++) push_word(words[k]);
        // Four words buffered behind the one being shifted.
        vectors++;
        if (fifo_level !== 3'd4 || din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_level: lvl=%0d rdy=%0b required 4 0", fifo_level, din_ready);
        end
        din       = words[5];
        din_valid = 1'b1;
        stall = 0;
        while (!din_ready && stall < 20) begin
            vectors++;
            if (fifo_level !== 3'd4) begin
                miscompares++;
                $display("FAIL full_stall_level: lvl=%0d required 4", fifo_level);
            end
            stall++;
            tick();
        end
        // First word popped at edge 1, ends at edge 9 which pops the next.
        vectors++;
        if (stall != 5 || fifo_level !== 3'd3) begin
            miscompares++;
            $display("FAIL full_ready_return: stall=%0d lvl=%0d required 5 3", stall, fifo_level);
        end
        tick();
        din_valid = 1'b0;
        vectors++;
        if (fifo_level !== 3'd4) begin
            miscompares++;
            $display("FAIL full_late_push: lvl=%0d required 4", fifo_level);
        end
        for (int i = 0; i < 50; i++) tick();
        for (int k = 0; k < 6; k++)
            for (int b = 7; b >= 0; b--) expq.push_back(words[k][b]);
        vectors++;
        if (bitq.size() != 48 || words_sent !== 16'd6) begin
            miscompares++;
            $display("FAIL full_count: bits=%0d ws=%0d required 48 6", bitq.size(), words_sent);
        end else begin
            for (int i = 0; i < 48; i++) begin
                vectors++;
                if (bitq[i] !== expq[i]) begin
                    miscompares++;
                    $display("FAIL full_order[%0d]: x=%0b required %0b", i, bitq[i], expq[i]);
                end
            end
        end
    endtask

    // Runs straight after test_full so words_sent is non-zero going in.
    task automatic test_reset_mid();
        logic [7:0] w;
        clear_mon();
        push_word(8'hC3);
        push_word(8'h5A);
        push_word(8'h0F);
        tick();
        tick();
        // Now just after the edge presenting bit 3 of the first word.
        vectors++;
        if (x_valid !== 1'b1 || fifo_level !== 3'd2) begin
            miscompares++;
            $display("FAIL mid_setup: xv=%0b lvl=%0d required 1 2", x_valid, fifo_level);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({x, x_valid, frame_start, fifo_level, words_sent} !== {1'b0, 1'b0, 1'b0, 3'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL mid_reset: x=%0b xv=%0b fs=%0b lvl=%0d ws=%0d required 0 0 0 0 0",
                     x, x_valid, frame_start, fifo_level, words_sent);
        end
        #2 reset = 1'b0;
        vectors++;
        if (din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_release_ready: rdy=%0b required 1", din_ready);
        end
        tick();
        clear_mon();
        w = 8'h96;
        push_word(w);
        for (int i = 0; i < 12; i++) tick();
        vectors++;
        if (bitq.size() != 8 || fscyc.size() != 1 || words_sent !== 16'd1) begin
            miscompares++;
            $display("FAIL mid_after_count: bits=%0d fs=%0d ws=%0d required 8 1 1",
                     bitq.size(), fscyc.size(), words_sent);
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (bitq[i] !== w[7-i]) begin
                    miscompares++;
                    $display("FAIL mid_after_bit[%0d]: x=%0b required %0b", i, bitq[i], w[7-i]);
                end
            end
        end
    endtask

    // Stream 0000_0101 then 1000_0000: pattern 1011 appears only across the
    // word boundary, completing on stream bit 8 (first bit of word two).
    task automatic test_detector();
        logic [3:0] hist;
        int hits;
        int hit_idx;
        do_reset();
        push_word(8'h05);
        push_word(8'h80);
        for (int i = 0; i < 20; i++) tick();
        hist = 4'b0;
        hits = 0;
        hit_idx = -1;
        for (int i = 0; i < bitq.size(); i++) begin
            hist = {hist[2:0], bitq[i]};
            if (i >= 3 && hist == 4'b1011) begin
                hits++;
                hit_idx = i;
            end
        end
        vectors++;
        if (hits != 1 || hit_idx != 8) begin
            miscompares++;
            $display("FAIL det_hit: hits=%0d idx=%0d required 1 8", hits, hit_idx);
        end
        vectors++;
        if (bitq.size() != 16 || bitcyc[15] - bitcyc[0] != 15) begin
            miscompares++;
            $display("FAIL det_contiguous: bits=%0d required 16 contiguous", bitq.size());
        end
        vectors++;
        if (words_sent !== 16'd2) begin
            miscompares++;
            $display("FAIL det_words_sent: got %0d required 2", words_sent);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        din         = '0;
        din_valid   = 1'b0;
        #12;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_detector();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
